// File: rtl/ov5640_cfg_pkg.sv
// Shared state encoding and table-field constants for the OV5640 configuration sequencer.
// Defining CFG_READBACK_EN adds the verify states used by the readback build.
package ov5640_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
`ifdef CFG_READBACK_EN
        ,
        ST_VERIFY_ISSUE,
        ST_VERIFY_WAIT
`endif
    } cfg_state_e;

    localparam int REG_ADDR_MSB = 23;
    localparam int REG_ADDR_LSB = 8;
    localparam int REG_VAL_MSB  = 7;
    localparam int REG_VAL_LSB  = 0;

    localparam logic [15:0] DEF_DELAY_MARK = 16'hFFFF;
    localparam int          DEF_CLK_PER_MS = 50000;

endpackage

// File: rtl/cfg_ms_timer.sv
// Loadable millisecond countdown: after load with ms>0 it pulses done in the
// last cycle of exactly ms*CLK_PER_MS cycles. clr abandons a running count.
module cfg_ms_timer
    import ov5640_cfg_pkg::*;
#(
    parameter int CLK_PER_MS = DEF_CLK_PER_MS
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       load,
    input  logic       clr,
    input  logic [7:0] ms,
    output logic       done
);

    localparam logic [15:0] CYC_LAST = 16'(CLK_PER_MS - 1);

    logic [15:0] cyc_cnt;
    logic [7:0]  ms_cnt;
    logic        active;

    assign done = active && (cyc_cnt == CYC_LAST) && (ms_cnt == 8'd1);

    always_ff @(posedge clk_50M) begin
        if (!reset_n || clr) begin
            active  <= 1'b0;
            cyc_cnt <= '0;
            ms_cnt  <= '0;
        end else if (load) begin
            active  <= (ms != 8'd0);
            cyc_cnt <= '0;
            ms_cnt  <= ms;
        end else if (active) begin
            if (cyc_cnt == CYC_LAST) begin
                cyc_cnt <= '0;
                ms_cnt  <= ms_cnt - 8'd1;
                if (ms_cnt == 8'd1) active <= 1'b0;
            end else begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Walks the OV5640 register table and issues one SCCB write per entry, with inline
// ms delays, NACK retry and done/error status. CFG_READBACK_EN adds a verify read per write.
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int          TBL_AW     = 8,
    parameter int          TBL_LEN    = 200,
    parameter int          RETRY_MAX  = 3,
    parameter int          CLK_PER_MS = DEF_CLK_PER_MS,
    parameter logic [15:0] DELAY_MARK = DEF_DELAY_MARK
) (
    input  logic              clk_50M,
    input  logic              reset_n,
    input  logic              initial_en,
    input  logic              cfg_restart,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [23:0]       tbl_data,
    output logic              sccb_req,
    output logic [15:0]       sccb_addr,
    output logic [7:0]        sccb_wdata,
    input  logic              sccb_ack,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              sccb_rd,
    input  logic [7:0]        sccb_rdata,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_error,
    output logic [TBL_AW-1:0] err_index
);

    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    cfg_state_e        state;
    logic [TBL_AW-1:0] idx;
    logic [RW-1:0]     retry;
    logic              drop_pend;
    logic              tmr_done;

    wire [15:0] dec_addr  = tbl_data[REG_ADDR_MSB:REG_ADDR_LSB];
    wire [7:0]  dec_val   = tbl_data[REG_VAL_MSB:REG_VAL_LSB];
    wire        dec_delay = (dec_addr == DELAY_MARK);
    wire        is_last   = (idx == TBL_AW'(TBL_LEN - 1));
    wire        can_retry = (retry < RW'(RETRY_MAX));

    // The next-entry step is folded into the WAIT/DELAY exits so cfg_done
    // follows the final sccb_done by a single cycle.
    wire cfg_state_e        adv_state = is_last ? ST_DONE : ST_FETCH;
    wire [TBL_AW-1:0]       adv_idx   = is_last ? idx : idx + TBL_AW'(1);

    assign tbl_addr = idx;
    assign cfg_busy = !(state == ST_IDLE || state == ST_DONE || state == ST_ERROR);

    cfg_ms_timer #(.CLK_PER_MS(CLK_PER_MS)) u_ms_timer (
        .clk_50M (clk_50M),
        .reset_n (reset_n),
        .load    (state == ST_DECODE && dec_delay),
        .clr     (!initial_en),
        .ms      (dec_val),
        .done    (tmr_done)
    );

`ifdef CFG_READBACK_EN
    logic rd_q;
    assign sccb_rd = rd_q;
    wire in_wait = (state == ST_WAIT) || (state == ST_VERIFY_WAIT);
`else
    logic unused_rdata;
    assign sccb_rd      = 1'b0;
    assign unused_rdata = ^sccb_rdata;
    wire in_wait = (state == ST_WAIT);
`endif

    always_ff @(posedge clk_50M) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            retry      <= '0;
            drop_pend  <= 1'b0;
            sccb_req   <= 1'b0;
            sccb_addr  <= '0;
            sccb_wdata <= '0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            err_index  <= '0;
`ifdef CFG_READBACK_EN
            rd_q       <= 1'b0;
`endif
        end else if ((!initial_en && !in_wait) ||
                     (in_wait && sccb_done && (drop_pend || !initial_en))) begin
            // Sensor lost power: abandon the walk, except that a transaction
            // already accepted by the master is allowed to complete first.
            state     <= ST_IDLE;
            idx       <= '0;
            retry     <= '0;
            drop_pend <= 1'b0;
            sccb_req  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            err_index <= '0;
`ifdef CFG_READBACK_EN
            rd_q      <= 1'b0;
`endif
        end else begin
            if (in_wait && !initial_en) drop_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    state <= ST_FETCH;
                    idx   <= '0;
                    retry <= '0;
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (dec_delay) begin
                        if (dec_val == 8'd0) begin
                            state    <= adv_state;
                            idx      <= adv_idx;
                            retry    <= '0;
                            cfg_done <= is_last;
                        end else begin
                            state <= ST_DELAY;
                        end
                    end else begin
                        sccb_addr  <= dec_addr;
                        sccb_wdata <= dec_val;
                        sccb_req   <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: if (sccb_ack) begin
                    sccb_req <= 1'b0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: if (sccb_done) begin
                    if (!sccb_nack) begin
`ifdef CFG_READBACK_EN
                        sccb_req <= 1'b1;
                        rd_q     <= 1'b1;
                        state    <= ST_VERIFY_ISSUE;
`else
                        state    <= adv_state;
                        idx      <= adv_idx;
                        retry    <= '0;
                        cfg_done <= is_last;
`endif
                    end else if (can_retry) begin
                        retry    <= retry + RW'(1);
                        sccb_req <= 1'b1;
                        state    <= ST_ISSUE;
                    end else begin
                        cfg_error <= 1'b1;
                        err_index <= idx;
                        state     <= ST_ERROR;
                    end
                end
`ifdef CFG_READBACK_EN
                ST_VERIFY_ISSUE: if (sccb_ack) begin
                    sccb_req <= 1'b0;
                    rd_q     <= 1'b0;
                    state    <= ST_VERIFY_WAIT;
                end
                ST_VERIFY_WAIT: if (sccb_done) begin
                    if (!sccb_nack && sccb_rdata == sccb_wdata) begin
                        state    <= adv_state;
                        idx      <= adv_idx;
                        retry    <= '0;
                        cfg_done <= is_last;
                    end else if (can_retry) begin
                        retry    <= retry + RW'(1);
                        sccb_req <= 1'b1;
                        state    <= ST_ISSUE;
                    end else begin
                        cfg_error <= 1'b1;
                        err_index <= idx;
                        state     <= ST_ERROR;
                    end
                end
`endif
                ST_DELAY: if (tmr_done) begin
                    state    <= adv_state;
                    idx      <= adv_idx;
                    retry    <= '0;
                    cfg_done <= is_last;
                end
                ST_DONE, ST_ERROR: if (cfg_restart) begin
                    cfg_done  <= 1'b0;
                    cfg_error <= 1'b0;
                    err_index <= '0;
                    idx       <= '0;
                    retry     <= '0;
                    state     <= ST_FETCH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Scoreboarded bench: a behavioural SCCB master checks each accepted write against
// the queue of writes the stimulus expects, plus timing and status checks.
module tb_ov5640_cfg_sequencer;

    localparam int TBL_AW   = 8;
    localparam int DONE_DLY = 4;
    localparam int CPM      = 10;
    // Cycles outside DELAY between a write's sccb_done and the next sccb_req when
    // one delay entry sits between them: WAIT exit, FETCH+DECODE of the delay
    // entry, FETCH+DECODE of the next write.
    localparam int SEQ_OVH  = 5;

    logic              clk_50M = 1'b0;
    logic              reset_n, initial_en, cfg_restart;
    logic [TBL_AW-1:0] tbl_addr, err_index;
    logic [23:0]       tbl_data;
    logic              sccb_req, sccb_ack, sccb_done, sccb_nack, sccb_rd;
    logic [15:0]       sccb_addr;
    logic [7:0]        sccb_wdata, sccb_rdata;
    logic              cfg_busy, cfg_done, cfg_error;

    ov5640_cfg_sequencer #(
        .TBL_AW(TBL_AW), .TBL_LEN(3), .RETRY_MAX(2), .CLK_PER_MS(CPM), .DELAY_MARK(16'hFFFF)
    ) dut (
        .clk_50M(clk_50M), .reset_n(reset_n), .initial_en(initial_en), .cfg_restart(cfg_restart),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .sccb_req(sccb_req), .sccb_addr(sccb_addr), .sccb_wdata(sccb_wdata),
        .sccb_ack(sccb_ack), .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .sccb_rd(sccb_rd), .sccb_rdata(sccb_rdata),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .err_index(err_index)
    );

    always #10 clk_50M = ~clk_50M;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    logic [23:0] rom [0:3];
    always @(posedge clk_50M) tbl_data <= rom[tbl_addr[1:0]];

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    logic [23:0] sb[$];
    int          ack_dly = 0, stab_chk = 0;
    logic [15:0] nack_addr = 16'h0, cnt_addr = 16'h0;
    int          nack_left = 0, req_cnt = 0, done_cnt = 0;
    int          t_done = 0, last_gap = 0;

    // SCCB master model: ack after ack_dly cycles, done DONE_DLY cycles later.
    initial begin
        int          sph, wcnt, dcnt;
        logic        req_d;
        logic [15:0] cur_a, hold_a;
        logic [7:0]  cur_d, hold_d;
        logic [23:0] want;
        sph = 0; wcnt = 0; dcnt = 0; req_d = 1'b0;
        cur_a = '0; cur_d = '0; hold_a = '0; hold_d = '0;
        sccb_ack = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0; sccb_rdata = '0;
        forever begin
            @(negedge clk_50M);
            sccb_ack = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
            if (!reset_n) begin
                sph = 0; req_d = 1'b0;
            end else begin
                if (sccb_req && !req_d) begin
                    last_gap = cyc - t_done;
                    hold_a = sccb_addr; hold_d = sccb_wdata; wcnt = 0;
                end
                if (sph == 0 && sccb_req) begin
                    if (stab_chk != 0 && wcnt > 0) begin
                        chk("hold_req", sccb_req, 1'b1);
                        chk("hold_addr", sccb_addr, hold_a);
                        chk("hold_data", sccb_wdata, hold_d);
                    end
                    if (wcnt < ack_dly) begin
                        wcnt++;
                    end else begin
                        sccb_ack = 1'b1;
                        cur_a = sccb_addr; cur_d = sccb_wdata;
                        sph = 1; dcnt = DONE_DLY;
                        if (!sccb_rd) begin
                            if (cur_a == cnt_addr) req_cnt++;
                            if (sb.size() == 0) chk("sb_extra_req", sb.size(), 1);
                            else begin
                                want = sb.pop_front();
                                chk("wr_addr", cur_a, want[23:8]);
                                chk("wr_data", cur_d, want[7:0]);
                            end
                        end
                    end
                end else if (sph == 1) begin
                    if (dcnt > 1) dcnt--;
                    else begin
                        sccb_done  = 1'b1;
                        sccb_rdata = cur_d;
                        if (cur_a == nack_addr && nack_left != 0) begin
                            sccb_nack = 1'b1;
                            if (nack_left != 255) nack_left--;
                        end else begin
                            t_done = cyc;
                            done_cnt++;
                        end
                        sph = 0;
                    end
                end
                req_d = sccb_req;
            end
        end
    end

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(cfg_done || cfg_error) && n < budget) begin
            @(negedge clk_50M);
            n++;
        end
        chk(tag, cfg_done | cfg_error, 1'b1);
    endtask

    task automatic pulse_restart();
        cfg_restart = 1'b1;
        @(negedge clk_50M);
        cfg_restart = 1'b0;
    endtask

    task automatic load_normal();
        rom[0] = 24'h3008_82; rom[1] = 24'h3103_11; rom[2] = 24'h3017_FF; rom[3] = 24'h0;
    endtask

    task automatic push_normal();
        sb.push_back(24'h3008_82); sb.push_back(24'h3103_11); sb.push_back(24'h3017_FF);
    endtask

    initial begin
        int d0, n;
        reset_n = 1'b0; initial_en = 1'b0; cfg_restart = 1'b0;
        load_normal();
        repeat (4) @(negedge clk_50M);
        chk("rst_busy", cfg_busy, 1'b0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_error", cfg_error, 1'b0);
        chk("rst_req", sccb_req, 1'b0);
        chk("rst_tbl_addr", tbl_addr, 8'h0);
        chk("rst_err_index", err_index, 8'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_50M);
        chk("idle_wait_en", cfg_busy, 1'b0);

        // Normal walk
        push_normal();
        initial_en = 1'b1;
        wait_end("walk_end", 2000);
        chk("walk_done", cfg_done, 1'b1);
        chk("walk_done_lat", cyc - t_done, 1);
        chk("walk_busy", cfg_busy, 1'b0);
        chk("walk_error", cfg_error, 1'b0);
        chk("walk_sb_left", sb.size(), 0);

        // initial_en falling beats a simultaneous restart
        cfg_restart = 1'b1; initial_en = 1'b0;
        @(negedge clk_50M);
        cfg_restart = 1'b0;
        chk("race_busy", cfg_busy, 1'b0);
        chk("race_done", cfg_done, 1'b0);

        // Single NACK on entry 0, then success
        nack_addr = 16'h3008; nack_left = 1; cnt_addr = 16'h3008; req_cnt = 0;
        sb.push_back(24'h3008_82);
        push_normal();
        initial_en = 1'b1;
        wait_end("retry_ok_end", 2000);
        chk("retry_ok_done", cfg_done, 1'b1);
        chk("retry_ok_reqs", req_cnt, 2);
        chk("retry_ok_sb_left", sb.size(), 0);

        // Entry 1 always NACKs: 1 + RETRY_MAX attempts, then error
        initial_en = 1'b0;
        repeat (2) @(negedge clk_50M);
        nack_addr = 16'h3103; nack_left = 255; cnt_addr = 16'h3103; req_cnt = 0;
        sb.push_back(24'h3008_82);
        repeat (3) sb.push_back(24'h3103_11);
        initial_en = 1'b1;
        wait_end("err_end", 2000);
        chk("err_flag", cfg_error, 1'b1);
        chk("err_index", err_index, 8'd1);
        chk("err_no_done", cfg_done, 1'b0);
        repeat (30) @(negedge clk_50M);
        chk("err_reqs", req_cnt, 3);
        chk("err_sb_left", sb.size(), 0);
        chk("err_held", cfg_error, 1'b1);

        // Restart from ERROR
        nack_left = 0;
        push_normal();
        pulse_restart();
        chk("rs_error_clr", cfg_error, 1'b0);
        chk("rs_index_clr", err_index, 8'h0);
        chk("rs_tbl_addr", tbl_addr, 8'h0);
        chk("rs_busy", cfg_busy, 1'b1);
        wait_end("rs_end", 2000);
        chk("rs_done", cfg_done, 1'b1);
        chk("rs_sb_left", sb.size(), 0);

        // Delay entry of 5 ms between two writes
        rom[1] = 24'hFFFF_05;
        sb.push_back(24'h3008_82); sb.push_back(24'h3017_FF);
        pulse_restart();
        wait_end("dly_end", 2000);
        chk("dly_gap", last_gap, 5 * CPM + SEQ_OVH);
        chk("dly_done", cfg_done, 1'b1);
        chk("dly_sb_left", sb.size(), 0);

        // initial_en dropped mid-delay, then reasserted
        sb.push_back(24'h3008_82);
        d0 = done_cnt;
        pulse_restart();
        n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk_50M);
            n++;
        end
        chk("abort_first_write", done_cnt - d0, 1);
        repeat (12) @(negedge clk_50M);
        chk("abort_busy_pre", cfg_busy, 1'b1);
        initial_en = 1'b0;
        @(negedge clk_50M);
        chk("abort_busy", cfg_busy, 1'b0);
        chk("abort_req", sccb_req, 1'b0);
        repeat (80) @(negedge clk_50M);
        chk("abort_quiet", sb.size(), 0);
        sb.push_back(24'h3008_82); sb.push_back(24'h3017_FF);
        initial_en = 1'b1;
        @(negedge clk_50M);
        chk("reen_tbl_addr", tbl_addr, 8'h0);
        chk("reen_busy", cfg_busy, 1'b1);
        wait_end("reen_end", 2000);
        chk("reen_done", cfg_done, 1'b1);
        chk("reen_sb_left", sb.size(), 0);

        // Ack withheld 20 cycles: request must hold steady
        load_normal();
        ack_dly = 20; stab_chk = 1;
        push_normal();
        pulse_restart();
        wait_end("hold_end", 3000);
        ack_dly = 0; stab_chk = 0;
        chk("hold_done", cfg_done, 1'b1);
        chk("hold_sb_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
